// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - writeback queue in front of the 8x8 register file write port
// Queued results retire one per clock; define WBQ_FORWARD_EN to build read-port forwarding.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     FLUSH,
  input  logic                     RES_VALID,
  output logic                     RES_READY,
  input  logic [DATA_W-1:0]        RES_DATA,
  input  logic [ADDR_W-1:0]        RES_ADDR,
  input  logic                     WB_STALL,
  output logic                     WB_WRITE,
  output logic [ADDR_W-1:0]        WB_ADDR,
  output logic [DATA_W-1:0]        WB_DATA,
  input  logic [ADDR_W-1:0]        RD1_ADDR,
  input  logic [ADDR_W-1:0]        RD2_ADDR,
  output logic                     FWD1_HIT,
  output logic [DATA_W-1:0]        FWD1_DATA,
  output logic                     FWD2_HIT,
  output logic [DATA_W-1:0]        FWD2_DATA,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_w;
  logic              pop_w;

  assign RES_READY = (count_q != CNT_W'(DEPTH));
  assign WB_WRITE  = (count_q != '0) && !WB_STALL;
  assign WB_ADDR   = (count_q != '0) ? addr_q[head_q] : '0;
  assign WB_DATA   = (count_q != '0) ? data_q[head_q] : '0;
  assign COUNT     = count_q;
  assign push_w    = RES_VALID && RES_READY;
  assign pop_w     = WB_WRITE;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (FLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_w) tail_d = tail_q + 1'b1;
      if (pop_w)  head_d = head_q + 1'b1;
      if (push_w && !pop_w)      count_d = count_q + 1'b1;
      else if (pop_w && !push_w) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry contents need no reset: count_q gates every read of them.
  always_ff @(posedge CLK) begin
    if (push_w && !FLUSH) begin
      data_q[tail_q] <= RES_DATA;
      addr_q[tail_q] <= RES_ADDR;
    end
  end

`ifdef WBQ_FORWARD_EN
  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    idx       = '0;
    FWD1_HIT  = 1'b0;
    FWD1_DATA = '0;
    FWD2_HIT  = 1'b0;
    FWD2_DATA = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (addr_q[idx] == RD1_ADDR) begin
          FWD1_HIT  = 1'b1;
          FWD1_DATA = data_q[idx];
        end
        if (addr_q[idx] == RD2_ADDR) begin
          FWD2_HIT  = 1'b1;
          FWD2_DATA = data_q[idx];
        end
      end
    end
  end
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^{RD1_ADDR, RD2_ADDR};
  assign FWD1_HIT  = 1'b0;
  assign FWD1_DATA = '0;
  assign FWD2_HIT  = 1'b0;
  assign FWD2_DATA = '0;
`endif

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Writeback buffer directly upstream of the 8x8 register file; owns the file's write port (IN, INADDRESS, WRITE).
- Accepts ALU/load results through a valid/ready handshake and queues them in a small FIFO.
- Retires at most one entry per clock into the register file.
- Forwards still-queued data to the two register-file read ports so operand reads never see stale values.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2
DATA_W, 8, result / register width
ADDR_W, 3, register address width (8 registers)

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  asynchronous, active-low reset
FLUSH  input  1  synchronous clear of all queued entries
RES_VALID  input  1  upstream result valid
RES_READY  output  1  queue can accept a result this cycle
RES_DATA  input  DATA_W  result value
RES_ADDR  input  ADDR_W  destination register
WB_STALL  input  1  hold retirement this cycle
WB_WRITE  output  1  to register file WRITE
WB_ADDR  output  ADDR_W  to register file INADDRESS
WB_DATA  output  DATA_W  to register file IN
RD1_ADDR  input  ADDR_W  mirrors register file OUT1ADDRESS
RD2_ADDR  input  ADDR_W  mirrors register file OUT2ADDRESS
FWD1_HIT  output  1  queued value exists for RD1_ADDR
FWD1_DATA  output  DATA_W  youngest queued value for RD1_ADDR
FWD2_HIT  output  1  as FWD1_HIT, for RD2_ADDR
FWD2_DATA  output  DATA_W  as FWD1_DATA, for RD2_ADDR
COUNT  output  log2(DEPTH)+1  entries currently queued

Behaviour:
- Storage: circular buffer of DEPTH entries {data, addr}, with head pointer, tail pointer and count.
- Reset (RESET low, asynchronous): pointers = 0, COUNT = 0, WB_WRITE = 0, RES_READY = 1. WB_ADDR, WB_DATA, FWD*_DATA = 0. FWD*_HIT = 0. Entry contents are don't-care.
- RES_READY = (COUNT != DEPTH). It does not depend on same-cycle retirement, so there is no combinational path from WB_STALL to RES_READY.
- Push: at the clock edge where RES_VALID and RES_READY are both 1, write {RES_DATA, RES_ADDR} at the tail and advance the tail (wrap at DEPTH).
- Retire:
  - WB_WRITE = (COUNT != 0) and not WB_STALL.
  - WB_ADDR / WB_DATA = head entry, combinational; 0 when empty.
  - At an edge where WB_WRITE is 1, pop the head; the register file samples the same edge.
- Latency: a result pushed at edge N is presented on WB_* during cycle N+1 and written at edge N+1, provided the queue was empty and there is no stall. There is no same-cycle bypass of an empty queue.
- Simultaneous push and pop: COUNT unchanged; both pointers advance.
- Full plus pop in the same cycle: the push is still refused (RES_READY was 0).
- Pointer wrap: DEPTH - 1 wraps to 0. COUNT distinguishes full from empty.
- FLUSH: at the next edge, pointers and COUNT go to 0. Any push and pop in that cycle are discarded; the WB_WRITE asserted in that cycle still writes the register file.
- RESET low mid-operation: the queue empties immediately and WB_WRITE drops asynchronously; queued entries are lost.
- Forwarding (combinational):
  - Scan the valid entries, head to tail.
  - FWDn_HIT = 1 if any valid entry's addr == RDn_ADDR.
  - FWDn_DATA = data of the youngest (nearest-tail) match; 0 if no match.
  - The entry being retired this cycle counts as queued.
- COUNT is registered and is valid one edge after each push/pop.

Optional Feature:
WBQ_FORWARD_EN
- Defined: forwarding logic present as described above.
- Undefined: FWD1_HIT, FWD2_HIT, FWD1_DATA, FWD2_DATA are tied to 0 and no compare logic is built. The consumer must then stall reads while COUNT != 0. All other behaviour is identical.

Test Plan:
1. Reset, then push {0x06, r2} with WB_STALL = 0 -> cycle after push: WB_WRITE = 1, WB_ADDR = 2, WB_DATA = 0x06; COUNT returns to 0 one edge later.
2. WB_STALL = 1; push 0x11 to r1, 0x22 to r2, 0x33 to r3, 0x44 to r4 -> COUNT = 4, RES_READY = 0, a fifth push is refused. Release the stall -> four writes in order r1..r4 on consecutive cycles.
3. WB_STALL = 1; push {0xE6, r3} then {0x5A, r3}; set RD1_ADDR = 3, RD2_ADDR = 5 -> FWD1_HIT = 1, FWD1_DATA = 0x5A; FWD2_HIT = 0, FWD2_DATA = 0.
4. Full queue, WB_STALL = 0, RES_VALID held -> one pop per cycle. Each push is accepted on the edge after RES_READY rises. Pointers wrap past DEPTH - 1 with data order preserved over 10 pushes.
5. Three entries queued, pulse FLUSH for one cycle -> COUNT = 0 and WB_WRITE = 0 next cycle. The head written in the FLUSH cycle is the only one retired.
6. Three entries queued, drive RESET low between edges -> WB_WRITE = 0 and COUNT = 0 immediately. After RESET goes high, RES_READY = 1 and no stale write occurs.
